counter_updown_m: RTL

//  Parametrised successor to the basic loadable up-counter. Adds count enable,
//  up/down direction, programmable terminal value (limit), wrap or saturate

---
 rtl/counter_pkg.sv | 16 +
 rtl/counter_updown_m.sv | 76 +++++++
 2 files changed

// File: rtl/counter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : counter_pkg
// Description : Shared types for the up/down terminal counter.
// Revision    : 1.0 - initial release
// ============================================================================
package counter_pkg;

  // Boundary policy: WRAP jumps to the opposite end, SAT sticks at the end.
  typedef enum logic {
    CNT_WRAP = 1'b0,
    CNT_SAT  = 1'b1
  } cnt_mode_e;

endpackage : counter_pkg
`default_nettype wire

// File: rtl/counter_updown_m.sv
`default_nettype none
// ============================================================================
// Module      : counter_updown_m
// Description : Loadable up/down counter over 0..limit with count enable,
//               wrap or saturate boundary policy, registered terminal-count
//               pulse and sticky overflow flag.
// Revision    : 1.0 - initial release
// ============================================================================
module counter_updown_m
  import counter_pkg::*;
#(
  parameter int        W    = 5,
  parameter cnt_mode_e MODE = CNT_WRAP
) (
  input  logic         clk,
  input  logic         rst_,
  input  logic         load,
  input  logic [W-1:0] data,
  input  logic         en,
  input  logic         up,
  input  logic [W-1:0] limit,
  output logic [W-1:0] count,
  output logic         tc,
  output logic         ovf
);

  logic [W-1:0] count_nxt;
  logic         tc_nxt;
  logic         ovf_nxt;

  // Next-state selection: load beats enable, enable beats hold.
  always_comb begin
    count_nxt = count;
    tc_nxt    = 1'b0;
    ovf_nxt   = ovf;
    if (load) begin
      count_nxt = data;
      ovf_nxt   = 1'b0;
    end else if (en) begin
      if (up) begin
        // A loaded value above limit is treated as already at the boundary.
        if (count >= limit) begin
          count_nxt = (MODE == CNT_SAT) ? limit : '0;
          tc_nxt    = 1'b1;
          ovf_nxt   = 1'b1;
        end else begin
          count_nxt = count + W'(1);
        end
      end else begin
        // Counting down from above limit is an ordinary step.
        if (count == '0) begin
          count_nxt = (MODE == CNT_SAT) ? '0 : limit;
          tc_nxt    = 1'b1;
          ovf_nxt   = 1'b1;
        end else begin
          count_nxt = count - W'(1);
        end
      end
    end
  end

  // State register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      count <= '0;
      tc    <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      count <= count_nxt;
      tc    <= tc_nxt;
      ovf   <= ovf_nxt;
    end
  end

endmodule : counter_updown_m
`default_nettype wire
